// File: rtl/ddram_rom_writer.sv
// Packs the 16-bit hps_io ioctl download stream into 64-bit DDRAM writes.
// Single-beat writes with byte enables; back-pressures hps_io via ioctl_wait.
module ddram_rom_writer #(
  parameter logic [28:0] BASE_ADDR = 29'h0300_0000,
  parameter logic [7:0]  INDEX     = 8'd0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  input  logic        ddram_busy,
  output logic        ddram_we,
  output logic [28:0] ddram_addr,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be,
  output logic [3:0]  ddram_burstcnt,
  output logic        rom_loaded,
  output logic [23:0] words_written
);

  typedef enum logic [1:0] {
    FILL, FLUSH, DRAIN, DONE
  } state_t;

  state_t      r_state;
  logic        r_act_q;
  logic        r_asm_v;
  logic [23:0] r_asm_tag;
  logic [63:0] r_asm_d;
  logic [7:0]  r_asm_be;
  logic        r_sk_v;
  logic [23:0] r_sk_tag;
  logic [1:0]  r_sk_lane;
  logic [15:0] r_sk_d;

  logic        w_act;
  logic        w_rise;
  logic        w_stb;
  logic [1:0]  w_lane;
  logic [23:0] w_line;
  logic        w_e_v;
  logic [23:0] w_e_tag;
  logic [63:0] w_e_d;
  logic [7:0]  w_e_be;
  logic        w_n_v;
  logic [23:0] w_n_tag;
  logic [63:0] w_n_d;
  logic [7:0]  w_n_be;
  logic        w_sk_load;
  logic        w_n_sv;
  logic        w_drain;
  logic        w_trig;
  logic        w_unused;

  assign w_act  = ioctl_download && (ioctl_index == INDEX);
  assign w_rise = w_act && !r_act_q;
  assign w_stb  = w_act && ioctl_wr;
  assign w_lane = ioctl_addr[2:1];
  assign w_line = ioctl_addr[26:3];
  assign w_unused = ioctl_addr[0];
  assign ddram_burstcnt = 4'd1;

  // An empty assembly register takes the skid word straight away,
  // so ordering is kept and the skid slot is free again next cycle.
  always_comb begin
    w_e_v   = r_asm_v | r_sk_v;
    w_e_tag = r_asm_tag;
    w_e_d   = r_asm_d;
    w_e_be  = r_asm_be;
    if (!r_asm_v) begin
      w_e_tag = r_sk_tag;
      w_e_d   = '0;
      w_e_be  = '0;
      w_e_d[{r_sk_lane, 4'b0} +: 16] = r_sk_d;
      w_e_be[{r_sk_lane, 1'b0} +: 2] = 2'b11;
    end
    w_n_v     = w_e_v;
    w_n_tag   = w_e_tag;
    w_n_d     = w_e_d;
    w_n_be    = w_e_be;
    w_sk_load = 1'b0;
    if (w_stb) begin
      if (!w_e_v || (w_e_tag == w_line)) begin
        if (!w_e_v) begin
          w_n_tag = w_line;
          w_n_d   = '0;
          w_n_be  = '0;
        end
        w_n_v = 1'b1;
        w_n_d[{w_lane, 4'b0} +: 16] = ioctl_dout;
        w_n_be[{w_lane, 1'b0} +: 2] = 2'b11;
      end else if (!(r_asm_v && r_sk_v)) begin
        w_sk_load = 1'b1;
      end
    end
    w_n_sv  = (r_asm_v && r_sk_v) || w_sk_load;
    w_drain = !w_act && ((r_state == DRAIN) ||
              ((r_state == FILL) && r_act_q));
    w_trig  = (r_state != FLUSH) && w_n_v &&
              ((w_n_be == 8'hFF) || w_n_sv || w_drain);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= FILL;
      r_act_q       <= 1'b0;
      r_asm_v       <= 1'b0;
      r_asm_tag     <= '0;
      r_asm_d       <= '0;
      r_asm_be      <= '0;
      r_sk_v        <= 1'b0;
      r_sk_tag      <= '0;
      r_sk_lane     <= '0;
      r_sk_d        <= '0;
      ioctl_wait    <= 1'b0;
      ddram_we      <= 1'b0;
      ddram_addr    <= '0;
      ddram_din     <= '0;
      ddram_be      <= '0;
      rom_loaded    <= 1'b0;
      words_written <= '0;
    end else begin
      r_act_q   <= w_act;
      r_asm_v   <= w_n_v && !w_trig;
      r_asm_tag <= w_n_tag;
      r_asm_d   <= w_n_d;
      r_asm_be  <= w_n_be;
      r_sk_v    <= w_n_sv;
      if (w_sk_load) begin
        r_sk_tag  <= w_line;
        r_sk_lane <= w_lane;
        r_sk_d    <= ioctl_dout;
      end
      ioctl_wait <= w_n_sv ||
                    ((r_state == FLUSH) && ddram_busy && w_n_v);
      case (r_state)
        FLUSH: begin
          if (!ddram_busy) begin
            ddram_we <= 1'b0;
            if (words_written != 24'hFFFFFF)
              words_written <= words_written + 24'd1;
            if (w_act) begin
              r_state <= FILL;
            end else if (w_n_v) begin
              r_state <= DRAIN;
            end else begin
              rom_loaded <= 1'b1;
              r_state    <= DONE;
            end
          end
        end
        default: begin
          if (w_trig) begin
            ddram_we   <= 1'b1;
            ddram_addr <= BASE_ADDR + {5'd0, w_n_tag};
            ddram_din  <= w_n_d;
            ddram_be   <= w_n_be;
            r_state    <= FLUSH;
          end else if (w_drain) begin
            rom_loaded <= 1'b1;
            r_state    <= DONE;
          end else if (w_act) begin
            r_state <= FILL;
          end
        end
      endcase
      if (w_rise) begin
        rom_loaded    <= 1'b0;
        words_written <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ddram_rom_writer.sv
// Directed and randomized bench for ddram_rom_writer.
// Expected DDRAM writes come from a line-grouping model of the stream.
module tb_ddram_rom_writer;

  localparam logic [28:0] BASE  = 29'h0300_0000;
  localparam logic [7:0]  INDEX = 8'd0;

  logic        clk;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        ddram_busy;
  logic        ddram_we;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic [3:0]  ddram_burstcnt;
  logic        rom_loaded;
  logic [23:0] words_written;

  ddram_rom_writer #(.BASE_ADDR(BASE), .INDEX(INDEX)) dut (
    .clk_sys        (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .ddram_busy     (ddram_busy),
    .ddram_we       (ddram_we),
    .ddram_addr     (ddram_addr),
    .ddram_din      (ddram_din),
    .ddram_be       (ddram_be),
    .ddram_burstcnt (ddram_burstcnt),
    .rom_loaded     (rom_loaded),
    .words_written  (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [28:0] a;
    logic [63:0] d;
    logic [7:0]  be;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mw;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_wr    = 0;
  int          n_we_cyc = 0;
  logic        m_v;
  logic [23:0] m_tag;
  logic [63:0] m_d;
  logic [7:0]  m_be;
  int          m_cnt;
  logic        done;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_emit();
    wr_t w;
    w.a  = BASE + {5'd0, m_tag};
    w.d  = m_d;
    w.be = m_be;
    exp_q.push_back(w);
    m_v = 1'b0;
    m_cnt++;
  endfunction

  // A write per run of same-line words, split whenever a line fills.
  function automatic void m_word(input logic [26:0] a,
                                 input logic [15:0] d);
    if (m_v && (a[26:3] != m_tag)) m_emit();
    if (!m_v) begin
      m_v = 1'b1;
      m_tag = a[26:3];
      m_d = '0;
      m_be = '0;
    end
    m_d[{a[2:1], 4'b0} +: 16] = d;
    m_be[{a[2:1], 1'b0} +: 2] = 2'b11;
    if (m_be == 8'hFF) m_emit();
  endfunction

  task automatic send(input logic [26:0] a, input logic [15:0] d);
    int n = 0;
    while (ioctl_wait && n < 200) begin
      tick();
      n++;
    end
    chk("wait_bound", 64'(n < 200), 1);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    if (ioctl_download && ioctl_index == INDEX) m_word(a, d);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    m_v   = 1'b0;
    m_cnt = 0;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    if (ioctl_index == INDEX && m_v) m_emit();
  endtask

  task automatic wait_loaded();
    int n = 0;
    while (!rom_loaded && n < 100) begin
      tick();
      n++;
    end
    chk("loaded_bound", 64'(n < 100), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"},   ddram_we, 0);
    chk({tag, "_addr"}, ddram_addr, 0);
    chk({tag, "_din"},  ddram_din, 0);
    chk({tag, "_be"},   ddram_be, 0);
    chk({tag, "_wait"}, ioctl_wait, 0);
    chk({tag, "_rl"},   rom_loaded, 0);
    chk({tag, "_ww"},   words_written, 0);
  endtask

  always @(negedge clk) begin
    if (reset_n && ddram_we) begin
      n_we_cyc++;
      if (!ddram_busy) begin
        n_wr++;
        chk("sb_pending", 64'(exp_q.size() != 0), 1);
        chk("sb_burst", ddram_burstcnt, 1);
        if (exp_q.size() != 0) begin
          mw = exp_q.pop_front();
          chk("sb_addr", ddram_addr, mw.a);
          chk("sb_din", ddram_din, mw.d);
          chk("sb_be", ddram_be, mw.be);
        end
      end
    end
  end

  initial begin
    logic [28:0] sa;
    logic [63:0] sd;
    logic [7:0]  sb;
    int          k;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    ddram_busy = 1'b0;
    done = 1'b0;
    m_v = 1'b0;
    m_cnt = 0;
    tick();
    tick();
    chk_zero("rst");
    reset_n = 1'b1;
    tick();

    // full line, busy low
    start_dl(INDEX);
    chk("t1_rl0", rom_loaded, 0);
    send(27'h0, 16'h1111);
    send(27'h2, 16'h2222);
    send(27'h4, 16'h3333);
    send(27'h6, 16'h4444);
    chk("t1_we", ddram_we, 1);
    chk("t1_addr", ddram_addr, BASE);
    chk("t1_din", ddram_din, 64'h4444_3333_2222_1111);
    chk("t1_be", ddram_be, 8'hFF);
    tick();
    chk("t1_we_drop", ddram_we, 0);
    chk("t1_ww", words_written, 1);
    end_dl();
    tick();
    chk("t1_rl", rom_loaded, 1);

    // partial line flushed at end of download
    start_dl(INDEX);
    chk("t2_rl_clr", rom_loaded, 0);
    chk("t2_ww_clr", words_written, 0);
    send(27'h10, 16'h1111);
    send(27'h12, 16'h2222);
    end_dl();
    tick();
    chk("t2_we", ddram_we, 1);
    chk("t2_addr", ddram_addr, BASE + 29'd2);
    chk("t2_be", ddram_be, 8'h0F);
    chk("t2_din", ddram_din, 64'h2222_1111);
    chk("t2_rl_early", rom_loaded, 0);
    tick();
    chk("t2_rl", rom_loaded, 1);
    chk("t2_we_drop", ddram_we, 0);

    // line jump through the skid
    start_dl(INDEX);
    send(27'h0, 16'hAAAA);
    send(27'h20, 16'hBBBB);
    chk("t3_we", ddram_we, 1);
    chk("t3_addr", ddram_addr, BASE);
    chk("t3_be", ddram_be, 8'h03);
    chk("t3_wait", ioctl_wait, 1);
    tick();
    chk("t3_wait_drop", ioctl_wait, 0);
    end_dl();
    wait_loaded();
    chk("t3_ww", words_written, 2);

    // busy stretch during a full-line flush
    start_dl(INDEX);
    for (int i = 0; i < 4; i++)
      send(27'(32'h40 + 2 * i), 16'($urandom));
    ddram_busy = 1'b1;
    chk("t4_we", ddram_we, 1);
    chk("t4_addr", ddram_addr, BASE + 29'd8);
    sa = ddram_addr;
    sd = ddram_din;
    sb = ddram_be;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          tick();
          chk("t4_we_hold", ddram_we, 1);
          chk("t4_addr_hold", ddram_addr, sa);
          chk("t4_din_hold", ddram_din, sd);
          chk("t4_be_hold", ddram_be, sb);
          chk("t4_wait_hold", ioctl_wait, 1);
        end
        ddram_busy = 1'b0;
        tick();
        chk("t4_we_drop", ddram_we, 0);
      end
      begin
        for (int i = 4; i < 16; i++)
          send(27'(32'h40 + 2 * i), 16'($urandom));
      end
    join
    end_dl();
    wait_loaded();
    chk("t4_ww", words_written, 4);
    chk("t4_q_empty", 64'(exp_q.size()), 0);

    // non-matching index after a fresh reset
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    k = n_we_cyc;
    start_dl(8'd1);
    for (int i = 0; i < 8; i++)
      send(27'(2 * i), 16'($urandom));
    tick();
    chk("t5_no_we", 64'(n_we_cyc - k), 0);
    chk("t5_ww", words_written, 0);
    chk("t5_rl", rom_loaded, 0);
    end_dl();
    tick();
    tick();
    chk("t5_rl_end", rom_loaded, 0);

    // reset while a write is pending
    start_dl(INDEX);
    ddram_busy = 1'b1;
    for (int i = 0; i < 4; i++)
      send(27'(32'h80 + 2 * i), 16'($urandom));
    chk("t6_we", ddram_we, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("t6_rst");
    exp_q.delete();
    m_v = 1'b0;
    ioctl_download = 1'b0;
    ddram_busy = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    start_dl(INDEX);
    send(27'h0, 16'h5A5A);
    send(27'h2, 16'hA5A5);
    end_dl();
    wait_loaded();
    chk("t6_ww", words_written, 1);

    // random addresses with random busy
    start_dl(INDEX);
    done = 1'b0;
    fork
      begin
        while (!done) begin
          ddram_busy = ($urandom_range(0, 2) == 0);
          tick();
        end
      end
      begin
        for (int i = 0; i < 60; i++)
          send(27'($urandom_range(0, 31) * 2), 16'($urandom));
        done = 1'b1;
      end
    join
    ddram_busy = 1'b0;
    end_dl();
    wait_loaded();
    chk("rnd_ww", words_written, 24'(m_cnt));
    chk("rnd_q_empty", 64'(exp_q.size()), 0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
